// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd_addr;
  logic             ex_redirect;
  logic             imem_valid;
  logic             mem_access;
  logic             dmem_ready;
  logic             pc_en;
  logic             pc_sel_redirect;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             ex_mem_flush;
  logic             mem_wb_stall;
  logic             mem_wb_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic             dmem_timeout;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_mem_read,
           ex_rd_addr, ex_redirect, imem_valid, mem_access, dmem_ready,
    input  pc_en, pc_sel_redirect, if_id_stall, if_id_flush, id_ex_stall,
           id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush,
           stall_cycles, flush_events, dmem_timeout
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_mem_read,
           ex_rd_addr, ex_redirect, imem_valid, mem_access, dmem_ready,
    output pc_en, pc_sel_redirect, if_id_stall, if_id_flush, id_ex_stall,
           id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush,
           stall_cycles, flush_events, dmem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use, redirect,
// memory waits and stale-fetch discard, plus perf counters and a dmem timeout.
//   state | meaning
//   RUN   | no outstanding data-memory wait
//   DWAIT | data access in MEM still waiting for dmem_ready
module pipe_hazard_ctrl #(
  parameter int unsigned DMEM_TIMEOUT = 255,
  parameter int          CNT_W        = 32
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave hz
);
  typedef enum logic {RUN = 1'b0, DWAIT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_CNT = DMEM_TIMEOUT[7:0];

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             drop_q, drop_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic dmem_busy, load_use, redirect_ok;
  logic pc_en, pc_sel, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_s, memwb_f;

  assign dmem_busy   = hz.mem_access && !hz.dmem_ready;
  assign redirect_ok = hz.ex_redirect && !dmem_busy;
  assign load_use    = hz.ex_mem_read && (hz.ex_rd_addr != 5'd0) &&
                       ((hz.id_uses_rs1 && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                        (hz.id_uses_rs2 && (hz.id_rs2_addr == hz.ex_rd_addr)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      drop_q      <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drop_q      <= drop_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 8'd0;
    timeout_d  = timeout_q;
    drop_d     = drop_q;
    pc_en      = 1'b0;
    pc_sel     = 1'b0;
    ifid_s     = 1'b0;
    ifid_f     = 1'b0;
    idex_s     = 1'b0;
    idex_f     = 1'b0;
    exmem_s    = 1'b0;
    exmem_f    = 1'b0;
    memwb_s    = 1'b0;
    memwb_f    = 1'b0;

    case (state_q)
      RUN: begin
        if (dmem_busy) state_d = DWAIT;
      end
      DWAIT: begin
        if (hz.dmem_ready) state_d = RUN;
        wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
        if (wait_cnt_q == TIMEOUT_CNT) timeout_d = 1'b1;
      end
      default: state_d = RUN;
    endcase

    // A redirect over a missing fetch leaves the old request in flight; its
    // eventual response belongs to the wrong path and must be dropped.
    if (redirect_ok)          drop_d = !hz.imem_valid;
    else if (hz.imem_valid)   drop_d = 1'b0;

    if (dmem_busy) begin
      ifid_s  = 1'b1;
      idex_s  = 1'b1;
      exmem_s = 1'b1;
      memwb_f = 1'b1;
    end else if (hz.ex_redirect) begin
      pc_en  = 1'b1;
      pc_sel = 1'b1;
      ifid_f = 1'b1;
      idex_f = 1'b1;
    end else if (load_use) begin
      ifid_s = 1'b1;
      idex_f = 1'b1;
    end else if (!hz.imem_valid || drop_q) begin
      ifid_f = 1'b1;
    end else begin
      pc_en = 1'b1;
    end

    stall_cnt_d = pc_en ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
    flush_cnt_d = redirect_ok ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // Reset overrides the decision so every stage register fills with bubbles.
  assign hz.pc_en           = reset ? 1'b0 : pc_en;
  assign hz.pc_sel_redirect = reset ? 1'b0 : pc_sel;
  assign hz.if_id_stall     = reset ? 1'b0 : ifid_s;
  assign hz.if_id_flush     = reset ? 1'b1 : ifid_f;
  assign hz.id_ex_stall     = reset ? 1'b0 : idex_s;
  assign hz.id_ex_flush     = reset ? 1'b1 : idex_f;
  assign hz.ex_mem_stall    = reset ? 1'b0 : exmem_s;
  assign hz.ex_mem_flush    = reset ? 1'b1 : exmem_f;
  assign hz.mem_wb_stall    = reset ? 1'b0 : memwb_s;
  assign hz.mem_wb_flush    = reset ? 1'b1 : memwb_f;
  assign hz.stall_cycles    = stall_cnt_q;
  assign hz.flush_events    = flush_cnt_q;
  assign hz.dmem_timeout    = timeout_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl, built with DMEM_TIMEOUT=4 so the
// timeout path is reachable in a few cycles.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 32;

  // {pc_en, sel, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_s, memwb_f}
  localparam logic [9:0] O_RUN  = 10'b10_0000_0000;
  localparam logic [9:0] O_LU   = 10'b00_1001_0000;
  localparam logic [9:0] O_RDR  = 10'b11_0101_0000;
  localparam logic [9:0] O_BUSY = 10'b00_1010_1001;
  localparam logic [9:0] O_FB   = 10'b00_0100_0000;
  localparam logic [9:0] O_RST  = 10'b00_0101_0101;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(.DMEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  logic [9:0] outs;
  assign outs = {hz.pc_en, hz.pc_sel_redirect, hz.if_id_stall, hz.if_id_flush,
                 hz.id_ex_stall, hz.id_ex_flush, hz.ex_mem_stall, hz.ex_mem_flush,
                 hz.mem_wb_stall, hz.mem_wb_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Check the combinational decision for the current inputs, then clock it in.
  task automatic cyc(input string tag, input logic [9:0] exp);
    #1 chk(tag, 32'(outs), 32'(exp));
    @(negedge clk);
  endtask

  task automatic idle();
    hz.id_rs1_addr = 5'd0;
    hz.id_rs2_addr = 5'd0;
    hz.id_uses_rs1 = 1'b0;
    hz.id_uses_rs2 = 1'b0;
    hz.ex_mem_read = 1'b0;
    hz.ex_rd_addr  = 5'd0;
    hz.ex_redirect = 1'b0;
    hz.imem_valid  = 1'b1;
    hz.mem_access  = 1'b0;
    hz.dmem_ready  = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs2);
    hz.ex_mem_read = 1'b1;
    hz.ex_rd_addr  = rd;
    hz.id_uses_rs2 = 1'b1;
    hz.id_rs2_addr = rs2;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #2;
    chk("rst_outs", 32'(outs), 32'(O_RST));
    chk("rst_stall", hz.stall_cycles, 0);
    chk("rst_flush", hz.flush_events, 0);
    chk("rst_tmo", 32'(hz.dmem_timeout), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    cyc("idle", O_RUN);

    set_lu(5'd5, 5'd5);
    cyc("lu_rs2", O_LU);
    idle();
    cyc("lu_after", O_RUN);
    chk("lu_stall_cnt", hz.stall_cycles, 1);

    set_lu(5'd0, 5'd0);
    cyc("lu_x0", O_RUN);
    idle();
    hz.ex_mem_read = 1'b1; hz.ex_rd_addr = 5'd7;
    hz.id_rs1_addr = 5'd7; hz.id_uses_rs1 = 1'b0;
    cyc("lu_rs1_unused", O_RUN);
    hz.id_uses_rs1 = 1'b1;
    cyc("lu_rs1", O_LU);
    idle();
    chk("lu2_stall_cnt", hz.stall_cycles, 2);

    hz.ex_redirect = 1'b1;
    cyc("redirect", O_RDR);
    idle();
    chk("rdr_flush_cnt", hz.flush_events, 1);
    cyc("rdr_after", O_RUN);

    hz.ex_redirect = 1'b1;
    set_lu(5'd9, 5'd9);
    cyc("rdr_over_lu", O_RDR);
    idle();
    chk("rdr_lu_flush_cnt", hz.flush_events, 2);
    chk("rdr_lu_stall_cnt", hz.stall_cycles, 2);

    hz.mem_access = 1'b1; hz.ex_redirect = 1'b1;
    cyc("dwait0", O_BUSY);
    chk("dwait_state", 32'(dut.state_q), 1);
    cyc("dwait1", O_BUSY);
    cyc("dwait2", O_BUSY);
    chk("dwait_flush_held", hz.flush_events, 2);
    hz.dmem_ready = 1'b1;
    cyc("dwait_ready_rdr", O_RDR);
    idle();
    chk("dwait_flush_cnt", hz.flush_events, 3);
    chk("dwait_stall_cnt", hz.stall_cycles, 5);
    chk("dwait_back_run", 32'(dut.state_q), 0);
    cyc("dwait_after", O_RUN);

    hz.ex_redirect = 1'b1; hz.imem_valid = 1'b0;
    cyc("drop_rdr", O_RDR);
    hz.ex_redirect = 1'b0;
    cyc("drop_miss1", O_FB);
    cyc("drop_miss2", O_FB);
    hz.imem_valid = 1'b1;
    cyc("drop_discard", O_FB);
    cyc("drop_next_ok", O_RUN);
    chk("drop_stall_cnt", hz.stall_cycles, 8);
    chk("drop_flush_cnt", hz.flush_events, 4);

    hz.mem_access = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("tmo_wait%0d", i), 32'(outs), 32'(O_BUSY));
      chk($sformatf("tmo_flag%0d", i), 32'(hz.dmem_timeout), 0);
      @(negedge clk);
    end
    chk("tmo_set", 32'(hz.dmem_timeout), 1);
    hz.dmem_ready = 1'b1;
    cyc("tmo_ready", O_RUN);
    idle();
    cyc("tmo_run", O_RUN);
    chk("tmo_sticky", 32'(hz.dmem_timeout), 1);
    chk("tmo_stall_cnt", hz.stall_cycles, 14);

    hz.mem_access = 1'b1;
    cyc("mid_w0", O_BUSY);
    cyc("mid_w1", O_BUSY);
    cyc("mid_w2", O_BUSY);
    chk("mid_cnt", 32'(dut.wait_cnt_q), 2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_outs", 32'(outs), 32'(O_RST));
    chk("mid_rst_state", 32'(dut.state_q), 0);
    chk("mid_rst_wcnt", 32'(dut.wait_cnt_q), 0);
    chk("mid_rst_tmo", 32'(hz.dmem_timeout), 0);
    chk("mid_rst_stall", hz.stall_cycles, 0);
    chk("mid_rst_flush", hz.flush_events, 0);
    @(negedge clk);
    idle();
    reset = 1'b0;
    cyc("post_rst", O_RUN);
    chk("post_rst_stall", hz.stall_cycles, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
